// File: rtl/proc_io_hub_pkg.sv
// Shared helpers and bit layouts for the proc_fx I/O hub.
package proc_io_hub_pkg;

  localparam int unsigned ERR_UNDER   = 0;
  localparam int unsigned ERR_OVER    = 1;
  localparam int unsigned NUM_ERR     = 2;
  localparam int unsigned STAT_IN_LSB = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Output-full bits sit directly above the input-empty bits in the status word.
  function automatic int unsigned stat_out_lsb(input int unsigned nuioin);
    return STAT_IN_LSB + nuioin;
  endfunction

endpackage

// File: rtl/proc_io_hub_fifo.sv
// Show-ahead synchronous FIFO; head reads as zero while empty.
module io_fifo
  import proc_io_hub_pkg::*;
#(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned FDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [NUBITS-1:0] din,
  output logic [NUBITS-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PW = clog2(FDEPTH);

  logic [PW:0]       wr_q, rd_q;
  logic [NUBITS-1:0] mem [FDEPTH];
  logic              do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (PW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[PW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rd_q[PW-1:0]];

endmodule

// File: rtl/proc_io_hub.sv
// Processor-facing I/O hub: buffered input/output channels, status word, sticky error flags.
module proc_io_hub
  import proc_io_hub_pkg::*;
#(
  parameter int unsigned NUBITS = 32,
  parameter int unsigned NUIOIN = 2,
  parameter int unsigned NUIOOU = 2,
  parameter int unsigned FDEPTH = 4,
  parameter int unsigned AIW    = clog2(NUIOIN + 1),
  parameter int unsigned AOW    = (clog2(NUIOOU) < 1) ? 1 : clog2(NUIOOU)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AIW-1:0]           proc_addr_in,
  input  logic                     proc_req_in,
  output logic [NUBITS-1:0]        proc_din,
  input  logic [AOW-1:0]           proc_addr_out,
  input  logic                     proc_out_en,
  input  logic [NUBITS-1:0]        proc_dout,
  input  logic [NUIOIN*NUBITS-1:0] in_data,
  input  logic [NUIOIN-1:0]        in_valid,
  output logic [NUIOIN-1:0]        in_ready,
  output logic [NUIOOU*NUBITS-1:0] out_data,
  output logic [NUIOOU-1:0]        out_valid,
  input  logic [NUIOOU-1:0]        out_ready,
  output logic [NUM_ERR-1:0]       err_flags,
  input  logic                     err_clr
);

  if (NUBITS < NUIOIN + NUIOOU) begin : g_bad_width
    $error("proc_io_hub: NUBITS too narrow for the status word");
  end

  logic [NUBITS-1:0]  in_dout  [NUIOIN];
  logic [NUBITS-1:0]  out_dout [NUIOOU];
  logic [NUIOIN-1:0]  in_full, in_empty, in_push, in_pop;
  logic [NUIOOU-1:0]  out_full, out_empty, out_push, out_pop;
  logic [NUBITS-1:0]  status;
  logic               under_set, over_set, addr_hit;
  logic [NUM_ERR-1:0] err_d, err_q;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (in_push[k]),
      .pop  (in_pop[k]),
      .din  (in_data[k*NUBITS +: NUBITS]),
      .dout (in_dout[k]),
      .full (in_full[k]),
      .empty(in_empty[k])
    );
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (out_push[k]),
      .pop  (out_pop[k]),
      .din  (proc_dout),
      .dout (out_dout[k]),
      .full (out_full[k]),
      .empty(out_empty[k])
    );
    assign out_data[k*NUBITS +: NUBITS] = out_dout[k];
  end

  assign in_ready  = ~in_full;
  assign in_push   = in_valid & ~in_full;
  assign out_valid = ~out_empty;
  assign out_pop   = out_ready & ~out_empty;

  always_comb begin
    status = '0;
    status[STAT_IN_LSB +: NUIOIN]          = in_empty;
    status[stat_out_lsb(NUIOIN) +: NUIOOU] = out_full;
  end

  // Read decode: data mux, pop strobes and underflow detection.
  always_comb begin
    proc_din  = '0;
    in_pop    = '0;
    under_set = 1'b0;
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      if (proc_addr_in == AIW'(k)) begin
        proc_din = in_dout[k];
        if (proc_req_in) begin
          if (in_empty[k]) under_set = 1'b1;
          else             in_pop[k] = 1'b1;
        end
      end
    end
    if (proc_addr_in == AIW'(NUIOIN)) proc_din = status;
  end

  // Write decode: push strobes and overflow detection.
  always_comb begin
    out_push = '0;
    over_set = 1'b0;
    addr_hit = 1'b0;
    for (int unsigned k = 0; k < NUIOOU; k++) begin
      if (proc_addr_out == AOW'(k)) begin
        addr_hit = 1'b1;
        if (proc_out_en) begin
          if (out_full[k] && !out_pop[k]) over_set    = 1'b1;
          else                            out_push[k] = 1'b1;
        end
      end
    end
    if (proc_out_en && !addr_hit) over_set = 1'b1;
  end

  always_comb begin
    err_d = err_clr ? '0 : err_q;
    if (under_set) err_d[ERR_UNDER] = 1'b1;
    if (over_set)  err_d[ERR_OVER]  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_flags = err_q;

endmodule

// File: tb/tb_proc_io_hub.sv
// Directed plus randomized bench for proc_io_hub against a queue-based reference model.
module tb_proc_io_hub;

  localparam int NB = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int FD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     proc_addr_in;
  logic           proc_req_in;
  logic [NB-1:0]  proc_din;
  logic [0:0]     proc_addr_out;
  logic           proc_out_en;
  logic [NB-1:0]  proc_dout;
  logic [NI*NB-1:0] in_data;
  logic [NI-1:0]  in_valid, in_ready;
  logic [NO*NB-1:0] out_data;
  logic [NO-1:0]  out_valid, out_ready;
  logic [1:0]     err_flags;
  logic           err_clr;

  int checks = 0;
  int errors = 0;

  logic [NB-1:0] qi [NI][$];
  logic [NB-1:0] qo [NO][$];
  logic [1:0]    m_err;

  proc_io_hub #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .proc_addr_in (proc_addr_in),
    .proc_req_in  (proc_req_in),
    .proc_din     (proc_din),
    .proc_addr_out(proc_addr_out),
    .proc_out_en  (proc_out_en),
    .proc_dout    (proc_dout),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_flags    (err_flags),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] exp_din();
    int a;
    logic [NB-1:0] s;
    a = int'(proc_addr_in);
    if (a < NI) return (qi[a].size() > 0) ? qi[a][0] : '0;
    if (a == NI) begin
      s = '0;
      for (int k = 0; k < NI; k++) s[k] = (qi[k].size() == 0);
      for (int k = 0; k < NO; k++) s[NI+k] = (qo[k].size() == FD);
      return s;
    end
    return '0;
  endfunction

  task automatic check_all();
    logic [NI-1:0]    e_rdy;
    logic [NO-1:0]    e_vld;
    logic [NO*NB-1:0] e_dat;
    for (int k = 0; k < NI; k++) e_rdy[k] = (qi[k].size() < FD);
    for (int k = 0; k < NO; k++) begin
      e_vld[k] = (qo[k].size() > 0);
      e_dat[k*NB +: NB] = e_vld[k] ? qo[k][0] : '0;
    end
    chk("in_ready", in_ready, e_rdy);
    chk("out_valid", out_valid, e_vld);
    chk("out_data", out_data, e_dat);
    chk("err_flags", err_flags, m_err);
    chk("proc_din", proc_din, exp_din());
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) qi[k].delete();
    for (int k = 0; k < NO; k++) qo[k].delete();
    m_err = '0;
  endtask

  // Applies one clock edge's worth of the hub's rules to the queues.
  task automatic model_update();
    logic [NI-1:0] rdy;
    logic [1:0]    set;
    int            a;
    if (rst) begin
      model_reset();
      return;
    end
    set = '0;
    for (int k = 0; k < NI; k++) rdy[k] = (qi[k].size() < FD);
    a = int'(proc_addr_in);
    if (proc_req_in && a < NI) begin
      if (qi[a].size() > 0) void'(qi[a].pop_front());
      else set[0] = 1'b1;
    end
    for (int k = 0; k < NO; k++)
      if (out_ready[k] && qo[k].size() > 0) void'(qo[k].pop_front());
    if (proc_out_en) begin
      a = int'(proc_addr_out);
      if (a >= NO) set[1] = 1'b1;
      else if (qo[a].size() < FD) qo[a].push_back(proc_dout);
      else set[1] = 1'b1;
    end
    for (int k = 0; k < NI; k++)
      if (in_valid[k] && rdy[k]) qi[k].push_back(in_data[k*NB +: NB]);
    m_err = (err_clr ? 2'b00 : m_err) | set;
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    proc_req_in = 1'b0;
    proc_out_en = 1'b0;
    in_valid    = '0;
    out_ready   = '0;
    err_clr     = 1'b0;
  endtask

  logic [NB-1:0] rd_exp [3];
  int            acc;

  initial begin
    rst = 1'b0;
    idle();
    in_data = '0; proc_dout = '0; proc_addr_in = '0; proc_addr_out = '0;
    model_reset();
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 2'b11);
    chk("rst_out_valid", out_valid, 2'b00);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_err", err_flags, 2'b00);
    chk("rst_din", proc_din, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Three words into ch0, then reset mid-run.
    in_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      in_data[NB-1:0] = 32'h100 + 32'(i);
      tick();
    end
    in_valid = '0;
    tick();
    chk("pre_rst_head", proc_din, 32'h100);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_in_ready", in_ready, 2'b11);
    chk("mid_rst_out_valid", out_valid, 2'b00);
    chk("mid_rst_err", err_flags, 2'b00);
    proc_addr_in = 2'd2;
    #1;
    chk("mid_rst_status", proc_din, 32'h3);
    tick();
    rst = 1'b0;

    // Input path on ch1 with sign preserved.
    rd_exp = '{32'd5, -32'sd7, 32'd9};
    proc_addr_in = 2'd1;
    in_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      in_data[NB +: NB] = rd_exp[i];
      tick();
    end
    in_valid = '0;
    proc_req_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rd_ch1", proc_din, rd_exp[i]);
      tick();
    end
    chk("rd_empty_data", proc_din, 32'h0);
    tick();
    chk("under_flag", err_flags, 2'b01);

    // Set beats a coincident clear; clear alone drops the flag.
    err_clr = 1'b1;
    tick();
    chk("clr_vs_set", err_flags, 2'b01);
    proc_req_in = 1'b0;
    tick();
    err_clr = 1'b0;
    chk("clr_alone", err_flags, 2'b00);

    // Overflow on output ch0.
    proc_addr_out = 1'b0;
    proc_out_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      proc_dout = 32'(i);
      tick();
    end
    proc_out_en = 1'b0;
    chk("ovf_valid", out_valid[0], 1'b1);
    chk("ovf_flag", err_flags, 2'b10);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    out_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", out_data[NB-1:0], 32'(i));
      tick();
    end
    chk("ovf_drained", out_valid, 2'b00);
    out_ready = '0;

    // Simultaneous pop and push on a full output FIFO.
    proc_out_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      proc_dout = 32'hA0 + 32'(i);
      tick();
    end
    proc_dout = 32'hA4;
    out_ready = 2'b01;
    tick();
    proc_out_en = 1'b0;
    out_ready = '0;
    chk("sim_no_ovf", err_flags, 2'b00);
    chk("sim_head", out_data[NB-1:0], 32'hA1);
    proc_addr_in = 2'd2;
    #1;
    chk("sim_status_full", proc_din, 32'h7);
    out_ready = 2'b01;
    for (int i = 0; i < 4; i++) tick();
    out_ready = '0;

    // Back-pressure on input ch0.
    proc_addr_in = 2'd0;
    in_valid = 2'b01;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_data[NB-1:0] = 32'h200 + 32'(i);
      if (in_ready[0]) acc++;
      tick();
    end
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_not_ready", in_ready[0], 1'b0);
    in_valid = '0;
    proc_req_in = 1'b1;
    tick();
    proc_req_in = 1'b0;
    chk("bp_ready_again", in_ready[0], 1'b1);
    proc_req_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    proc_req_in = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid      = 2'($urandom_range(0, 3));
      in_data       = {$urandom(), $urandom()};
      proc_addr_in  = 2'($urandom_range(0, 3));
      proc_req_in   = ($urandom_range(0, 2) == 0);
      proc_addr_out = 1'($urandom_range(0, 1));
      proc_out_en   = ($urandom_range(0, 2) == 0);
      proc_dout     = $urandom();
      out_ready     = 2'($urandom_range(0, 3));
      err_clr       = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
